rsa_modexp_ctrl: RTL and testbench

Sequencer that computes `result = base^exponent mod modulus` with a left-to-right binary square-and-multiply schedule. It owns a single shared modular-multiplier instance and drives it through that multiplier's ds/ready handshake, issuing one squaring per exponent bit and one multiply per set bit. It sits between the RSA top-level command interface and the modular multiplier datapath.

---
 rtl/rsa_modexp_ctrl_if.sv | 29 ++
 rtl/rsa_modexp_ctrl.sv | 135 +++++++++++++
 tb/tb_rsa_modexp_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rsa_modexp_ctrl_if.sv
// Command and modular-multiplier bus for rsa_modexp_ctrl.
// slave = controller view, master = environment (command source + multiplier).
interface rsa_modexp_ctrl_if #(
  parameter int MPWID = 1024
);
  logic             start;
  logic [MPWID-1:0] base;
  logic [MPWID-1:0] exponent;
  logic [MPWID-1:0] modulus;
  logic             busy;
  logic             done;
  logic [MPWID-1:0] result;
  logic [MPWID-1:0] mm_mpand;
  logic [MPWID-1:0] mm_mplier;
  logic [MPWID-1:0] mm_modulus;
  logic             mm_ds;
  logic             mm_ready;
  logic [MPWID-1:0] mm_product;

  modport slave (
    input  start, base, exponent, modulus, mm_ready, mm_product,
    output busy, done, result, mm_mpand, mm_mplier, mm_modulus, mm_ds
  );

  modport master (
    output start, base, exponent, modulus, mm_ready, mm_product,
    input  busy, done, result, mm_mpand, mm_mplier, mm_modulus, mm_ds
  );
endinterface

// File: rtl/rsa_modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving one shared modular multiplier.
// Define RSA_MODEXP_ZSKIP_EN to skip leading exponent zeros during SCAN.
module rsa_modexp_ctrl #(
  parameter int MPWID = 1024
) (
  input  logic              clk,
  input  logic              reset,
  rsa_modexp_ctrl_if.slave  bus
);
  localparam int IW = (MPWID > 1) ? $clog2(MPWID) : 1;
  localparam logic [IW-1:0]    IDX_MAX = IW'(MPWID - 1);
  localparam logic [MPWID-1:0] ONE     = MPWID'(1);

  typedef enum logic [3:0] {
    IDLE, SCAN, SQ_ISSUE, SQ_ACK, SQ_WAIT,
    MUL_ISSUE, MUL_ACK, MUL_WAIT, FINISH
  } state_t;

  state_t           r_state, w_state_nx;
  logic [MPWID-1:0] r_base, r_exp, r_mod, r_acc, r_result, r_mpand, r_mplier;
  logic [IW-1:0]    r_idx, w_idx_nx, w_idx_dec;
  logic [MPWID-1:0] w_acc_nx;
  logic             r_busy, r_done, w_ds, w_last;

  assign w_idx_dec = r_idx - IW'(1);
  assign w_last    = (r_idx == '0);

  always_comb begin
    w_state_nx = r_state;
    w_acc_nx   = r_acc;
    w_idx_nx   = r_idx;
    w_ds       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_nx = SCAN;
          w_idx_nx   = IDX_MAX;
        end
      end
      SCAN: begin
`ifdef RSA_MODEXP_ZSKIP_EN
        if (r_exp == '0) begin
          w_acc_nx   = ONE;
          w_state_nx = FINISH;
        end else if (r_exp[r_idx]) begin
          // Leading one: base^1 already in acc, so its square/multiply are skipped.
          w_acc_nx = r_base;
          if (w_last) begin
            w_state_nx = FINISH;
          end else begin
            w_idx_nx   = w_idx_dec;
            w_state_nx = SQ_ISSUE;
          end
        end else begin
          w_idx_nx = w_idx_dec;
        end
`else
        w_acc_nx   = ONE;
        w_state_nx = SQ_ISSUE;
`endif
      end
      SQ_ISSUE, MUL_ISSUE: begin
        if (bus.mm_ready) begin
          w_ds       = 1'b1;
          w_state_nx = (r_state == SQ_ISSUE) ? SQ_ACK : MUL_ACK;
        end
      end
      SQ_ACK:  if (!bus.mm_ready) w_state_nx = SQ_WAIT;
      MUL_ACK: if (!bus.mm_ready) w_state_nx = MUL_WAIT;
      SQ_WAIT, MUL_WAIT: begin
        if (bus.mm_ready) begin
          w_acc_nx = bus.mm_product;
          if (r_state == SQ_WAIT && r_exp[r_idx]) begin
            w_state_nx = MUL_ISSUE;
          end else if (w_last) begin
            w_state_nx = FINISH;
          end else begin
            w_idx_nx   = w_idx_dec;
            w_state_nx = SQ_ISSUE;
          end
        end
      end
      FINISH:  w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_base   <= '0;
      r_exp    <= '0;
      r_mod    <= '0;
      r_acc    <= '0;
      r_idx    <= IDX_MAX;
      r_result <= '0;
      r_mpand  <= '0;
      r_mplier <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_acc   <= w_acc_nx;
      r_idx   <= w_idx_nx;
      r_done  <= (r_state == FINISH);
      if (r_state == IDLE && bus.start) begin
        r_base <= bus.base;
        r_exp  <= bus.exponent;
        r_mod  <= bus.modulus;
        r_busy <= 1'b1;
      end
      if (r_state == FINISH) begin
        r_busy   <= 1'b0;
        r_result <= r_acc;
      end
      // Operands load from the next-acc value so a capture feeding straight
      // into an ISSUE state presents the freshly captured product.
      if (w_state_nx == SQ_ISSUE) begin
        r_mpand  <= w_acc_nx;
        r_mplier <= w_acc_nx;
      end else if (w_state_nx == MUL_ISSUE) begin
        r_mpand  <= w_acc_nx;
        r_mplier <= r_base;
      end
    end
  end

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.result     = r_result;
  assign bus.mm_mpand   = r_mpand;
  assign bus.mm_mplier  = r_mplier;
  assign bus.mm_modulus = r_mod;
  assign bus.mm_ds      = w_ds;
endmodule

// File: tb/tb_rsa_modexp_ctrl.sv
// Bench for rsa_modexp_ctrl: behavioural multiplier, operation-sequence scoreboard,
// vector table plus random vectors, busy-start and mid-multiply reset sequences.
module tb_rsa_modexp_ctrl;
  localparam int W = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rsa_modexp_ctrl_if #(.MPWID(W)) bus ();
  rsa_modexp_ctrl #(.MPWID(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mulmod(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] m);
    longint unsigned p;
    if (m == '0) return '0;
    p = longint'(a) * longint'(b);
    return W'(p % longint'(m));
  endfunction

  // Right-to-left exponentiation: independent of the controller's bit order.
  function automatic logic [W-1:0] ref_modexp(input logic [W-1:0] b, input logic [W-1:0] e,
                                              input logic [W-1:0] m);
    logic [W-1:0] r, x;
    r = W'(1);
    x = b;
    for (int i = 0; i < W; i++) begin
      if (e[i]) r = mulmod(r, x, m);
      x = mulmod(x, x, m);
    end
    return r;
  endfunction

  // Behavioural multiplier: random 2..5 cycle latency after ds.
  logic [2:0]   mm_cnt;
  logic [W-1:0] mm_pend;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.mm_ready   <= 1'b1;
      bus.mm_product <= '0;
      mm_cnt         <= '0;
      mm_pend        <= '0;
    end else if (bus.mm_ds && bus.mm_ready) begin
      bus.mm_ready <= 1'b0;
      mm_cnt       <= 3'($urandom_range(5, 2));
      mm_pend      <= mulmod(bus.mm_mpand, bus.mm_mplier, bus.mm_modulus);
    end else if (!bus.mm_ready) begin
      if (mm_cnt == '0) begin
        bus.mm_ready   <= 1'b1;
        bus.mm_product <= mm_pend;
      end else begin
        mm_cnt <= mm_cnt - 3'd1;
      end
    end
  end

  // Scoreboard: expected operation list (0 = square, 1 = multiply) and running value.
  bit           ops[$];
  logic [W-1:0] m_acc, m_base, m_mod;
  int           ds_cnt, done_cnt;
  bit           mul_seen;

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.mm_ds) begin
        bit op;
        ds_cnt++;
        chk("ds_needs_ready", bus.mm_ready, 1);
        if (ops.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_ds: got ds pulse %0d expected none", ds_cnt);
        end else begin
          op = ops.pop_front();
          chk("mm_mpand", bus.mm_mpand, m_acc);
          chk("mm_mplier", bus.mm_mplier, op ? m_base : m_acc);
          chk("mm_modulus", bus.mm_modulus, m_mod);
          if (op) mul_seen = 1'b1;
          m_acc = mulmod(m_acc, op ? m_base : m_acc, m_mod);
        end
      end
      if (bus.done) begin
        done_cnt++;
        chk("busy_low_with_done", bus.busy, 0);
      end
    end
  end

  task automatic prep(input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] m);
    int p;
    ops.delete();
    m_base = b; m_mod = m; ds_cnt = 0; done_cnt = 0; mul_seen = 1'b0;
`ifdef RSA_MODEXP_ZSKIP_EN
    p = -1;
    for (int i = W - 1; i >= 0; i--) if (e[i]) begin p = i; break; end
    m_acc = b;
    for (int i = p - 1; i >= 0; i--) begin
      ops.push_back(1'b0);
      if (e[i]) ops.push_back(1'b1);
    end
`else
    p = W;
    m_acc = W'(1);
    for (int i = p - 1; i >= 0; i--) begin
      ops.push_back(1'b0);
      if (e[i]) ops.push_back(1'b1);
    end
`endif
  endtask

  task automatic kick(input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] m);
    @(negedge clk);
    bus.start = 1'b1; bus.base = b; bus.exponent = e; bus.modulus = m;
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_after_start", bus.busy, 1);
    bus.base = W'($urandom); bus.exponent = W'($urandom); bus.modulus = W'($urandom);
  endtask

  task automatic run(input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] m,
                     input logic [W-1:0] r, input bit pulse);
    int n, exp_ds;
    prep(b, e, m);
    exp_ds = ops.size();
    kick(b, e, m);
    n = 0;
    while (!bus.done && n < 5000) begin
      @(negedge clk);
      n++;
      bus.start = 1'b0;
      if (!bus.done && pulse && (n % 7 == 3)) begin
        bus.start = 1'b1;
        bus.base = W'(2); bus.exponent = W'(5); bus.modulus = W'(11);
      end
    end
    bus.start = 1'b0;
    chk("done_within_budget", (n < 5000), 1);
    chk("result", bus.result, r);
    @(negedge clk);
    chk("done_one_cycle", bus.done, 0);
    chk("result_holds", bus.result, r);
    chk("ds_count", ds_cnt, exp_ds);
    chk("ops_left", ops.size(), 0);
    chk("done_pulses", done_cnt, 1);
    repeat (3) @(negedge clk);
    chk("idle_after_done", bus.busy, 0);
  endtask

  typedef struct {
    logic [W-1:0] b, e, m, r;
    bit           pulse;
  } vec_t;
  vec_t tbl[$];

`ifdef RSA_MODEXP_ZSKIP_EN
  localparam int DS_4_13 = 5;
  localparam int DS_EXP0 = 0;
`else
  localparam int DS_4_13 = 19;
  localparam int DS_EXP0 = 16;
`endif

  initial begin
    logic [W-1:0] rb, re, rm;
    int n;
    bus.start = 1'b0; bus.base = '0; bus.exponent = '0; bus.modulus = '0;

    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_ds", bus.mm_ds, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_mpand", bus.mm_mpand, 0);
    chk("rst_mplier", bus.mm_mplier, 0);
    chk("rst_modulus", bus.mm_modulus, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    tbl.push_back('{b: 16'd4, e: 16'd13, m: 16'd497, r: 16'd445, pulse: 1'b0});
    tbl.push_back('{b: 16'd3, e: 16'd0,  m: 16'd7,   r: 16'd1,   pulse: 1'b0});
    tbl.push_back('{b: 16'd5, e: 16'd3,  m: 16'd13,  r: 16'd8,   pulse: 1'b0});
    tbl.push_back('{b: 16'd2, e: 16'd1,  m: 16'd11,  r: 16'd2,   pulse: 1'b0});
    tbl.push_back('{b: 16'd4, e: 16'd13, m: 16'd497, r: 16'd445, pulse: 1'b1});
    tbl.push_back('{b: 16'd7, e: 16'hFFFF, m: 16'd65521,
                    r: ref_modexp(16'd7, 16'hFFFF, 16'd65521), pulse: 1'b0});
    tbl.push_back('{b: 16'd0, e: 16'h8000, m: 16'd3, r: 16'd0, pulse: 1'b0});
    for (int k = 0; k < 6; k++) begin
      rm = W'($urandom_range(65535, 3)) | W'(1);
      rb = W'($urandom % rm);
      re = W'($urandom);
      tbl.push_back('{b: rb, e: re, m: rm, r: ref_modexp(rb, re, rm), pulse: (k % 2 == 1)});
    end

    for (int i = 0; i < tbl.size(); i++) begin
      run(tbl[i].b, tbl[i].e, tbl[i].m, tbl[i].r, tbl[i].pulse);
      if (i == 0) chk("ds_count_4_13", ds_cnt, DS_4_13);
      if (i == 1) chk("ds_count_exp0", ds_cnt, DS_EXP0);
    end

    // Reset while a multiply is in flight, then a clean rerun.
    prep(16'd4, 16'd13, 16'd497);
    kick(16'd4, 16'd13, 16'd497);
    n = 0;
    while (!mul_seen && n < 5000) begin
      @(posedge clk);
      n++;
    end
    chk("mul_seen_before_reset", mul_seen, 1);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_ds", bus.mm_ds, 0);
    chk("abort_done", bus.done, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_no_done", done_cnt, 0);
    chk("abort_still_idle", bus.busy, 0);
    run(16'd4, 16'd13, 16'd497, 16'd445, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
